df_psums_dma_walker: RTL and testbench
======================================

Name: df_psums_dma_walker

Overview:
- Consumer side of the dataflow controller's partial-sums DMA pointer descriptor (ett, y_step, y_lim, k_step, k_lim).
- Accepts one descriptor plus a base address per tile and walks the two-level k/y offset loop.
- Emits one DMA burst request (address, length) per iteration over a valid/ready interface.
- Sits between the dataflow controller and the DMA engine request port.

Parameters:
- ADDR_W, 32, width of base and request addresses
- OFF_W, 24, width of ett, step and y-limit fields (k_lim is fixed at 12 bits)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- i_start_valid  in  1  descriptor valid
- o_start_ready  out  1  walker idle, can accept a descriptor
- i_base_addr  in  ADDR_W  tile base byte address
- i_ett  in  OFF_W  bytes per burst (elements-to-transfer in bytes)
- i_y_step  in  OFF_W  inner-loop byte stride
- i_y_lim  in  OFF_W  inner-loop exclusive byte-offset bound
- i_k_step  in  OFF_W  outer-loop byte stride
- i_k_lim  in  12  outer-loop exclusive byte-offset bound, zero-extended to OFF_W
- o_req_valid  out  1  burst request valid
- i_req_ready  in  1  DMA accepts request
- o_req_addr  out  ADDR_W  burst start address
- o_req_len  out  OFF_W  burst length in bytes (= captured ett)
- o_req_last  out  1  marks final request of the descriptor
- o_busy  out  1  high in any state other than IDLE
- o_done  out  1  one-cycle pulse when the descriptor is complete

Behaviour:
- One clock (i_clk). Reset is synchronous and active-high (i_rst).
- Reset values:
  - state = IDLE.
  - o_start_ready = 1.
  - o_req_valid, o_req_last, o_busy and o_done = 0.
  - o_req_addr, o_req_len and the internal offsets = 0.
- States: IDLE, ISSUE, DONE.
- IDLE:
  - o_start_ready = 1.
  - A start handshake (valid & ready) captures all descriptor fields into registers and clears y_off and k_off to 0.
  - If ett == 0, y_lim == 0 or k_lim == 0, the next state is DONE and no request is issued. Otherwise the next state is ISSUE.
- ISSUE:
  - o_req_valid = 1; o_start_ready = 0.
  - o_req_addr = base + k_off + y_off, truncated modulo 2^ADDR_W. o_req_len = ett.
  - addr, len and last are registered and stay stable while valid & !ready.
  - On a request handshake, compute y_nxt = y_off + y_step at OFF_W+1 bits (no wrap).
    - If y_step != 0 and y_nxt < y_lim: y_off <= y_nxt.
    - Otherwise y_off <= 0 and k advances by the same rule using k_step and k_lim.
    - If k also terminates, the next state is DONE.
  - A zero step terminates its loop after one iteration, so there is never an infinite loop.
  - o_req_last = 1 exactly when both loops terminate on the current handshake. It is computed combinationally from registered state and is valid whenever o_req_valid is high.
- DONE: o_done = 1 for exactly one cycle, then the next state is IDLE.
- Latency:
  - Start accepted in cycle N: first o_req_valid in cycle N+1.
  - Degenerate descriptor: o_done in cycle N+1.
  - Handshake of the last request in cycle M: o_done in cycle M+1, o_start_ready in cycle M+2.
- Throughput: one request per cycle when i_req_ready is held high.
- i_start_valid while busy: ignored (ready is low); the descriptor is not lost, because the upstream holds valid.
- Descriptor inputs are sampled only on the start handshake; later changes have no effect.
- Reset mid-operation: in the cycle after i_rst is high, o_req_valid = 0 and state = IDLE. No further requests and no o_done pulse for the aborted descriptor.
- Request count = ceil(y_lim / y_step) * ceil(k_lim / k_step), with each zero-step loop counted as 1.

Test Plan:
- Nominal walk: base=0x1000, ett=64, y_step=0x100, y_lim=0x300, k_step=0x1000, k_lim=0x800, ready always 1.
  - Expect 3 requests: 0x1000, 0x1100, 0x1200, each len=64, in consecutive cycles N+1..N+3.
  - o_req_last on 0x1200; o_done at N+4.
- Two-level walk: k_step=0x400, k_lim=0x800, other fields as in the nominal walk.
  - Expect 6 requests: 0x1000, 0x1100, 0x1200, 0x1400, 0x1500, 0x1600.
  - o_req_last only on 0x1600.
- Backpressure: same descriptor, i_req_ready randomly low ~50%.
  - addr, len and last stay stable while valid & !ready; the same 6 addresses appear in order; exactly one o_done.
- Degenerate cases:
  - y_lim=0: zero requests; o_done at N+1; o_start_ready high again at N+2.
  - y_step=0, y_lim=0x10, k_step=0, k_lim=1: exactly one request at base, with last=1.
- Overflow guard: y_step=0xFFFFFF, y_lim=0xFFFFFF, k_lim=1, base=0xFFFFFFF0.
  - Exactly one request, addr=0xFFFFFFF0; the loop terminates.
- Reset mid-walk: assert i_rst for 1 cycle after the 2nd handshake of the two-level walk.
  - Next cycle: o_req_valid=0, o_start_ready=1, and no o_done pulse.
  - A new descriptor is then accepted and walked from offset 0.

Source files
------------

// File: rtl/df_psums_dma_walker.sv
// Partial-sums DMA walker: takes one pointer descriptor per tile and
// issues one burst request per k/y loop iteration to the DMA engine.
module df_psums_dma_walker #(
  parameter int ADDR_W = 32,
  parameter int OFF_W  = 24
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start_valid,
  output logic              o_start_ready,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [OFF_W-1:0]  i_ett,
  input  logic [OFF_W-1:0]  i_y_step,
  input  logic [OFF_W-1:0]  i_y_lim,
  input  logic [OFF_W-1:0]  i_k_step,
  input  logic [11:0]       i_k_lim,
  output logic              o_req_valid,
  input  logic              i_req_ready,
  output logic [ADDR_W-1:0] o_req_addr,
  output logic [OFF_W-1:0]  o_req_len,
  output logic              o_req_last,
  output logic              o_busy,
  output logic              o_done
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [OFF_W-1:0]  y_step;
  logic [OFF_W-1:0]  y_lim;
  logic [OFF_W-1:0]  k_step;
  logic [OFF_W-1:0]  k_lim;
  logic [OFF_W-1:0]  y_off;
  logic [OFF_W-1:0]  k_off;

  logic [OFF_W:0]    y_nxt;
  logic [OFF_W:0]    k_nxt;
  logic              y_adv;
  logic              k_adv;
  logic [OFF_W-1:0]  y_new;
  logic [OFF_W-1:0]  k_new;
  logic              degen;

  // Sums carry one extra bit so a step near the field limit cannot wrap
  // back below the bound and loop forever.
  always_comb begin
    y_nxt = {1'b0, y_off} + {1'b0, y_step};
    k_nxt = {1'b0, k_off} + {1'b0, k_step};
    y_adv = (y_step != '0) && (y_nxt < {1'b0, y_lim});
    k_adv = (k_step != '0) && (k_nxt < {1'b0, k_lim});
    y_new = '0;
    k_new = k_off;
    if (y_adv) begin
      y_new = y_nxt[OFF_W-1:0];
    end else if (k_adv) begin
      k_new = k_nxt[OFF_W-1:0];
    end else begin
      k_new = '0;
    end
    degen = (i_ett == '0) || (i_y_lim == '0) || (i_k_lim == '0);
  end

  assign o_req_last = o_req_valid & ~y_adv & ~k_adv;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= IDLE;
      o_start_ready <= 1'b1;
      o_req_valid   <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_req_addr    <= '0;
      o_req_len     <= '0;
      base          <= '0;
      y_step        <= '0;
      y_lim         <= '0;
      k_step        <= '0;
      k_lim         <= '0;
      y_off         <= '0;
      k_off         <= '0;
    end else begin
      o_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_start_valid) begin
            base          <= i_base_addr;
            o_req_len     <= i_ett;
            y_step        <= i_y_step;
            y_lim         <= i_y_lim;
            k_step        <= i_k_step;
            k_lim         <= OFF_W'(i_k_lim);
            y_off         <= '0;
            k_off         <= '0;
            o_req_addr    <= i_base_addr;
            o_start_ready <= 1'b0;
            o_busy        <= 1'b1;
            if (degen) begin
              state  <= DONE;
              o_done <= 1'b1;
            end else begin
              state       <= ISSUE;
              o_req_valid <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (i_req_ready) begin
            if (y_adv || k_adv) begin
              y_off      <= y_new;
              k_off      <= k_new;
              o_req_addr <= base + ADDR_W'(k_new) + ADDR_W'(y_new);
            end else begin
              state       <= DONE;
              o_req_valid <= 1'b0;
              o_done      <= 1'b1;
              y_off       <= '0;
              k_off       <= '0;
            end
          end
        end
        DONE: begin
          state         <= IDLE;
          o_busy        <= 1'b0;
          o_start_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_df_psums_dma_walker.sv
// Bench for df_psums_dma_walker: descriptor table, reference loop model
// feeding a request scoreboard, plus a reset-abort sequence.
module tb_df_psums_dma_walker;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_start_valid;
  logic        o_start_ready;
  logic [31:0] i_base_addr;
  logic [23:0] i_ett;
  logic [23:0] i_y_step;
  logic [23:0] i_y_lim;
  logic [23:0] i_k_step;
  logic [11:0] i_k_lim;
  logic        o_req_valid;
  logic        i_req_ready;
  logic [31:0] o_req_addr;
  logic [23:0] o_req_len;
  logic        o_req_last;
  logic        o_busy;
  logic        o_done;

  df_psums_dma_walker #(.ADDR_W(32), .OFF_W(24)) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_start_valid(i_start_valid),
    .o_start_ready(o_start_ready),
    .i_base_addr  (i_base_addr),
    .i_ett        (i_ett),
    .i_y_step     (i_y_step),
    .i_y_lim      (i_y_lim),
    .i_k_step     (i_k_step),
    .i_k_lim      (i_k_lim),
    .o_req_valid  (o_req_valid),
    .i_req_ready  (i_req_ready),
    .o_req_addr   (o_req_addr),
    .o_req_len    (o_req_len),
    .o_req_last   (o_req_last),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] base;
    logic [23:0] ett;
    logic [23:0] ys;
    logic [23:0] yl;
    logic [23:0] ks;
    logic [11:0] kl;
    bit          rnd;
    int          cnt;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [23:0] len;
    logic        last;
  } exp_t;

  vec_t vecs[9];
  exp_t q[$];

  int  tests = 0;
  int  fails = 0;
  int  cyc = 0;
  int  hs_cnt = 0;
  int  done_cnt = 0;
  int  done_cyc = 0;
  bit  rnd_mode = 0;
  bit  hold = 0;
  exp_t held;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h (cyc %0d)",
               name, act, req, cyc);
    end
  endtask

  // Independent reference: iteration counts from ceil(), addresses by
  // index multiplication rather than running offsets.
  task automatic push_exp(input vec_t v);
    longint ny, nk;
    exp_t e;
    if (v.ett == 0 || v.yl == 0 || v.kl == 0) return;
    ny = (v.ys == 0) ? 1 : (longint'(v.yl) + longint'(v.ys) - 1) / longint'(v.ys);
    nk = (v.ks == 0) ? 1 : (longint'(v.kl) + longint'(v.ks) - 1) / longint'(v.ks);
    for (longint i = 0; i < nk; i++) begin
      for (longint j = 0; j < ny; j++) begin
        e.addr = v.base + 32'(i * longint'(v.ks)) + 32'(j * longint'(v.ys));
        e.len  = v.ett;
        e.last = (i == nk - 1) && (j == ny - 1);
        q.push_back(e);
      end
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (rnd_mode) i_req_ready = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    exp_t e;
    if (o_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (hold) begin
      chk("hold_valid", 64'(o_req_valid), 64'd1);
      chk("hold_addr", 64'(o_req_addr), 64'(held.addr));
      chk("hold_len", 64'(o_req_len), 64'(held.len));
      chk("hold_last", 64'(o_req_last), 64'(held.last));
    end
    hold = 0;
    if (!i_rst && o_req_valid) begin
      if (i_req_ready) begin
        hs_cnt++;
        if (q.size() == 0) begin
          chk("unexpected_req", 64'(o_req_addr), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = q.pop_front();
          chk("req_addr", 64'(o_req_addr), 64'(e.addr));
          chk("req_len", 64'(o_req_len), 64'(e.len));
          chk("req_last", 64'(o_req_last), 64'(e.last));
        end
      end else begin
        hold = 1;
        held.addr = o_req_addr;
        held.len  = o_req_len;
        held.last = o_req_last;
      end
    end
  end

  task automatic start_desc(input vec_t v);
    @(posedge clk); #1;
    i_start_valid = 1'b1;
    i_base_addr   = v.base;
    i_ett         = v.ett;
    i_y_step      = v.ys;
    i_y_lim       = v.yl;
    i_k_step      = v.ks;
    i_k_lim       = v.kl;
    @(posedge clk); #1;
    i_start_valid = 1'b0;
    i_base_addr   = 32'hDEAD_BEEF;
    i_ett         = 24'h0;
    i_y_step      = 24'h1;
    i_y_lim       = 24'hFFFFFF;
    i_k_step      = 24'h3;
    i_k_lim       = 12'hFFF;
  endtask

  task automatic run_desc(input vec_t v);
    int h, hs0, dn0, lim;
    @(negedge clk); #1;
    chk("idle_ready", 64'(o_start_ready), 64'd1);
    hs0 = hs_cnt;
    dn0 = done_cnt;
    push_exp(v);
    rnd_mode = v.rnd;
    start_desc(v);
    @(negedge clk); #1;
    h = cyc;
    chk("first_valid", 64'(o_req_valid), 64'(v.cnt > 0));
    chk("early_done", 64'(o_done), 64'(v.cnt == 0));
    lim = 0;
    while (done_cnt == dn0 && lim < 400) begin
      @(negedge clk); #1;
      lim++;
    end
    if (done_cnt == dn0) begin
      chk("done_timeout", 64'd0, 64'd1);
    end else begin
      if (!v.rnd) chk("done_cycle", 64'(done_cyc), 64'(h + v.cnt));
      chk("busy_in_done", 64'(o_busy), 64'd1);
      chk("ready_in_done", 64'(o_start_ready), 64'd0);
    end
    chk("hs_count", 64'(hs_cnt - hs0), 64'(v.cnt));
    chk("queue_empty", 64'(q.size()), 64'd0);
    q.delete();
    rnd_mode = 0;
    i_req_ready = 1'b1;
    @(negedge clk); #1;
    chk("ready_after", 64'(o_start_ready), 64'd1);
    chk("done_pulse", 64'(o_done), 64'd0);
    repeat (3) @(negedge clk);
    #1;
    chk("done_once", 64'(done_cnt - dn0), 64'd1);
  endtask

  initial begin
    int dn0;
    vecs[0] = '{32'h1000, 24'd64, 24'h100, 24'h300, 24'h1000, 12'h800, 0, 3};
    vecs[1] = '{32'h1000, 24'd64, 24'h100, 24'h300, 24'h400, 12'h800, 0, 6};
    vecs[2] = '{32'h1000, 24'd64, 24'h100, 24'h300, 24'h400, 12'h800, 1, 6};
    vecs[3] = '{32'h1000, 24'd64, 24'h100, 24'h0, 24'h400, 12'h800, 0, 0};
    vecs[4] = '{32'h2000, 24'd32, 24'h0, 24'h10, 24'h0, 12'h1, 0, 1};
    vecs[5] = '{32'hFFFF_FFF0, 24'd16, 24'hFFFFFF, 24'hFFFFFF, 24'h0, 12'h1, 0, 1};
    vecs[6] = '{32'h3000, 24'd0, 24'h10, 24'h40, 24'h100, 12'h200, 0, 0};
    vecs[7] = '{32'h3000, 24'd8, 24'h10, 24'h40, 24'h100, 12'h0, 0, 0};
    vecs[8] = '{32'h4000, 24'd12, 24'h30, 24'h70, 24'h5, 12'hB, 1, 9};

    i_rst = 1'b1;
    i_req_ready = 1'b1;
    i_start_valid = 1'b0;
    i_base_addr = '0;
    i_ett = '0;
    i_y_step = '0;
    i_y_lim = '0;
    i_k_step = '0;
    i_k_lim = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(o_start_ready), 64'd1);
    chk("rst_valid", 64'(o_req_valid), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_addr", 64'(o_req_addr), 64'd0);
    chk("rst_len", 64'(o_req_len), 64'd0);
    @(posedge clk); #1;
    i_rst = 1'b0;

    for (int i = 0; i < 9; i++) run_desc(vecs[i]);

    dn0 = done_cnt;
    push_exp(vecs[1]);
    start_desc(vecs[1]);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #1;
    i_rst = 1'b1;
    i_req_ready = 1'b0;
    @(posedge clk); #1;
    i_rst = 1'b0;
    i_req_ready = 1'b1;
    @(negedge clk); #1;
    chk("abort_valid", 64'(o_req_valid), 64'd0);
    chk("abort_ready", 64'(o_start_ready), 64'd1);
    chk("abort_busy", 64'(o_busy), 64'd0);
    chk("abort_left", 64'(q.size()), 64'd4);
    q.delete();
    repeat (5) @(negedge clk);
    #1;
    chk("abort_no_done", 64'(done_cnt - dn0), 64'd0);
    run_desc(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cyc %0d required finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
